mac_seq: RTL and testbench

MAC_SEQ -- requirements
Module: mac_seq

---
 rtl/mac_seq.sv | 119 +++++++++++
 tb/tb_mac_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq.sv
// Dot-product sequencer: streams VEC_LEN operand pairs into an external MAC,
// waits out the MAC latency, then holds the captured accumulator until consumed.
module mac_seq #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned VEC_LEN    = 8,
  parameter int unsigned MAC_LAT    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_a,
  input  logic [DATA_WIDTH-1:0]     in_b,
  output logic [DATA_WIDTH-1:0]     mac_a,
  output logic [DATA_WIDTH-1:0]     mac_b,
  output logic                      mac_en,
  output logic                      mac_clr,
  input  logic [3*DATA_WIDTH-1:0]   mac_cout,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [3*DATA_WIDTH-1:0]   res_data,
  output logic                      busy
);

  localparam int unsigned RES_W  = 3 * DATA_WIDTH;
  localparam int unsigned CNT_W  = $clog2(VEC_LEN + 1);
  localparam int unsigned DCNT_W = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd1;
  localparam logic [2:0] STREAM = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;

  logic [2:0]            state, state_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [DCNT_W-1:0]     dcnt, dcnt_d;
  logic [DATA_WIDTH-1:0] mac_a_d, mac_b_d;
  logic                  mac_en_d;
  logic [RES_W-1:0]      res_data_d;
  logic                  hs;

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    dcnt_d     = dcnt;
    mac_a_d    = mac_a;
    mac_b_d    = mac_b;
    mac_en_d   = 1'b0;
    res_data_d = res_data;
    hs         = in_valid && in_ready;

    case (state)
      IDLE: begin
        if (in_valid) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = STREAM;
        cnt_d   = '0;
      end
      STREAM: begin
        if (hs) begin
          mac_a_d  = in_a;
          mac_b_d  = in_b;
          mac_en_d = 1'b1;
          cnt_d    = cnt + CNT_W'(1);
          if (cnt == CNT_W'(VEC_LEN - 1)) begin
            state_d = DRAIN;
            dcnt_d  = '0;
          end
        end
      end
      DRAIN: begin
        // Last drain cycle is the first in which mac_cout holds the final element.
        if (dcnt == DCNT_W'(MAC_LAT)) begin
          res_data_d = mac_cout;
          state_d    = HOLD;
        end else begin
          dcnt_d = dcnt + DCNT_W'(1);
        end
      end
      HOLD: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dcnt      <= '0;
      mac_a     <= '0;
      mac_b     <= '0;
      mac_en    <= 1'b0;
      mac_clr   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      dcnt      <= dcnt_d;
      mac_a     <= mac_a_d;
      mac_b     <= mac_b_d;
      mac_en    <= mac_en_d;
      mac_clr   <= (state_d == CLEAR);
      res_valid <= (state_d == HOLD);
      res_data  <= res_data_d;
      in_ready  <= (state_d == STREAM);
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq with a behavioural one-cycle-latency MAC.
module tb_mac_seq;

  localparam int unsigned DW  = 8;
  localparam int unsigned VL  = 4;
  localparam int unsigned LAT = 1;
  localparam int unsigned RW  = 3 * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a, in_b;
  logic [DW-1:0] mac_a, mac_b;
  logic          mac_en, mac_clr;
  logic [RW-1:0] mac_cout;
  logic          res_valid, res_ready;
  logic [RW-1:0] res_data;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Per-vector observations gathered by the monitor
  int clr_vec = 0;
  int en_vec  = 0;
  int en_before_clr = 0;
  int viol = 0;

  logic [RW-1:0] acc;

  typedef struct packed {
    logic [VL-1:0][DW-1:0] a;
    logic [VL-1:0][DW-1:0] b;
    logic [7:0]            gap_pos;
    logic [7:0]            gap_len;
    logic [7:0]            rr_delay;
    logic [RW-1:0]         exp;
  } vec_t;

  mac_seq #(.DATA_WIDTH(DW), .VEC_LEN(VL), .MAC_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_cout(mac_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural MAC: an element enabled in cycle c shows in mac_cout from cycle c+1.
  always @(posedge clk) begin
    if (mac_clr) acc <= '0;
    else if (mac_en) acc <= acc + RW'(mac_a) * RW'(mac_b);
  end
  assign mac_cout = acc;

  always @(negedge clk) begin
    if (mac_en) begin
      en_vec = en_vec + 1;
      if (clr_vec == 0) en_before_clr = 1;
    end
    if (mac_clr) clr_vec = clr_vec + 1;
    if (mac_clr && mac_en) viol = viol + 1;
    if (res_valid && (in_ready || mac_clr || mac_en)) viol = viol + 1;
    if (!busy && (in_ready || res_valid || mac_clr)) viol = viol + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_in_ready"}, 32'(in_ready), 0);
    chk({name, "_mac_a"}, 32'(mac_a), 0);
    chk({name, "_mac_b"}, 32'(mac_b), 0);
    chk({name, "_mac_en"}, 32'(mac_en), 0);
    chk({name, "_mac_clr"}, 32'(mac_clr), 0);
    chk({name, "_res_valid"}, 32'(res_valid), 0);
    chk({name, "_res_data"}, 32'(res_data), 0);
    chk({name, "_busy"}, 32'(busy), 0);
  endtask

  // Present a pair and complete one handshake; returns just after the accepting edge.
  task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit ok = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int t = 0; t < 20; t++) begin
      if (in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int k;
    clr_vec = 0;
    en_vec = 0;
    en_before_clr = 0;
    res_ready = (v.rr_delay == 0);
    for (int i = 0; i < int'(VL); i++) begin
      send_pair(v.a[i], v.b[i]);
      if (i == int'(v.gap_pos) && v.gap_len != 0 && i != int'(VL) - 1) begin
        in_valid = 1'b0;
        in_a = DW'($urandom);
        in_b = DW'($urandom);
        for (int g = 0; g < int'(v.gap_len); g++) begin
          @(posedge clk); @(negedge clk);
          chk({name, "_gap_mac_en"}, 32'(mac_en), 0);
          chk({name, "_gap_mac_a"}, 32'(mac_a), 32'(v.a[i]));
          chk({name, "_gap_mac_b"}, 32'(mac_b), 32'(v.b[i]));
        end
      end
    end
    // Operand changes outside STREAM must be ignored
    in_valid = 1'b0;
    in_a = DW'($urandom);
    in_b = DW'($urandom);
    k = 0;
    for (int t = 1; t <= 20; t++) begin
      @(posedge clk); @(negedge clk);
      in_valid = 1'($urandom);
      if (res_valid) begin k = t; break; end
    end
    in_valid = 1'b0;
    chk({name, "_latency"}, 32'(k), 32'(LAT + 1));
    chk({name, "_res_data"}, 32'(res_data), 32'(v.exp));
    chk({name, "_hold_in_ready"}, 32'(in_ready), 0);
    for (int d = 0; d < int'(v.rr_delay); d++) begin
      @(posedge clk); @(negedge clk);
      chk({name, "_hold_valid"}, 32'(res_valid), 1);
      chk({name, "_hold_data"}, 32'(res_data), 32'(v.exp));
      chk({name, "_hold_in_ready"}, 32'(in_ready), 0);
    end
    res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk({name, "_idle_valid"}, 32'(res_valid), 0);
    chk({name, "_idle_busy"}, 32'(busy), 0);
    chk({name, "_clr_pulses"}, 32'(clr_vec), 1);
    chk({name, "_en_count"}, 32'(en_vec), 32'(VL));
    chk({name, "_en_before_clr"}, 32'(en_before_clr), 0);
    res_ready = 1'b0;
  endtask

  vec_t tbl [5];
  vec_t rv;
  logic [RW-1:0] model;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_a = 8'hAA;
    in_b = 8'h55;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;

    // a, b packed with element 0 in the low byte
    tbl[0] = '{a: {8'd4, 8'd3, 8'd2, 8'd1}, b: {8'd8, 8'd7, 8'd6, 8'd5},
               gap_pos: 8'd0, gap_len: 8'd0, rr_delay: 8'd0, exp: 24'd70};
    tbl[1] = '{a: {4{8'd255}}, b: {4{8'd255}},
               gap_pos: 8'd0, gap_len: 8'd0, rr_delay: 8'd0, exp: 24'h03F804};
    tbl[2] = '{a: {8'd4, 8'd3, 8'd2, 8'd1}, b: {8'd8, 8'd7, 8'd6, 8'd5},
               gap_pos: 8'd1, gap_len: 8'd3, rr_delay: 8'd5, exp: 24'd70};
    tbl[3] = '{a: {4{8'd1}}, b: {4{8'd1}},
               gap_pos: 8'd0, gap_len: 8'd0, rr_delay: 8'd0, exp: 24'd4};
    tbl[4] = '{a: {4{8'd2}}, b: {4{8'd3}},
               gap_pos: 8'd0, gap_len: 8'd0, rr_delay: 8'd0, exp: 24'd24};
    for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Reset after the second handshake abandons the vector
    send_pair(8'd9, 8'd9);
    send_pair(8'd9, 8'd9);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_all_zero("midrst");
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); @(negedge clk);
      chk("midrst_no_valid", 32'(res_valid), 0);
    end
    run_vec(tbl[3], "after_rst");

    // Random vectors against the sum-of-products model
    for (int n = 0; n < 30; n++) begin
      model = '0;
      for (int i = 0; i < int'(VL); i++) begin
        rv.a[i] = DW'($urandom);
        rv.b[i] = DW'($urandom);
        model = model + RW'(rv.a[i]) * RW'(rv.b[i]);
      end
      rv.gap_pos = 8'($urandom_range(0, VL - 2));
      rv.gap_len = 8'($urandom_range(0, 3));
      rv.rr_delay = 8'($urandom_range(0, 3));
      rv.exp = model;
      run_vec(rv, $sformatf("rnd%0d", n));
    end

    chk("invariants", 32'(viol), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
